// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to TXDATA are queued in a small
// FIFO and shifted out on txd; STATUS is returned on a combinational read port.
module mmio_uart_tx #(
  parameter int unsigned    n            = 32,
  parameter logic [n-1:0]   BASE         = n'(32'h0000_0080),
  parameter int unsigned    DEPTH        = 4,
  parameter int unsigned    CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic [n-1:0] dataadr,
  input  logic [n-1:0] writedata,
  output logic [n-1:0] rdata,
  output logic         hit,
  output logic         txd
);

  localparam int unsigned  AW         = $clog2(DEPTH);
  localparam int unsigned  CW         = AW + 1;
  localparam int unsigned  BW         = $clog2(CLKS_PER_BIT);
  localparam logic [n-1:0] STATUS_ADR = BASE + n'(4);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic [BW-1:0] baud;

  logic push_req;
  logic clr_req;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic baud_done;
  logic unused_wdata;

  assign push_req     = memwrite && (dataadr == BASE);
  assign clr_req      = memwrite && (dataadr == STATUS_ADR);
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign pop          = (state == IDLE) && !empty;
  // A pop on the same edge frees a slot, so a store to a full FIFO still lands.
  assign push         = push_req && (!full || pop);
  assign baud_done    = (baud == BAUD_LAST);
  assign unused_wdata = ^writedata[n-1:8];

  // STATUS read port
  always_comb begin
    hit   = (dataadr == STATUS_ADR);
    rdata = '0;
    if (hit) begin
      rdata[0]      = full;
      rdata[1]      = empty;
      rdata[2]      = (state != IDLE);
      rdata[3]      = overflow;
      rdata[3+CW:4] = count;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= writedata[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (clr_req)               overflow <= 1'b0;
      else if (push_req && !push) overflow <= 1'b1;
    end
  end

  // Transmit FSM; txd is registered from the current state, one cycle behind it
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      txd    <= 1'b1;
      shreg  <= '0;
      bitcnt <= '0;
      baud   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shreg  <= mem[rptr];
            bitcnt <= '0;
            baud   <= '0;
            state  <= START;
          end
        end
        START: begin
          txd <= 1'b0;
          if (baud_done) begin
            baud  <= '0;
            state <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          txd <= shreg[0];
          if (baud_done) begin
            baud   <= '0;
            shreg  <= {1'b0, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= STOP;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          txd <= 1'b1;
          if (baud_done) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: scenario tasks checked against a transaction-level model
// that predicts STATUS and the full txd waveform from frame timing rules.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_0080;
  localparam logic [31:0] STAT  = 32'h0000_0084;
  localparam int          DEPTH = 4;
  localparam int          C     = 4;
  localparam int          FRAME = 10 * C;
  localparam int          MAXC  = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] rdata;
  logic        hit;
  logic        txd;

  int n_checks = 0;
  int n_fail = 0;
  int edge_n = 0;

  logic hist    [0:MAXC-1];
  logic exp_txd [0:MAXC-1];

  // model state
  logic [7:0] m_q [$];
  logic       m_ovf = 1'b0;
  int         m_last_pop = -100000;
  int         m_free = 0;

  mmio_uart_tx #(
    .n(32), .BASE(BASE), .DEPTH(DEPTH), .CLKS_PER_BIT(C)
  ) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .rdata(rdata), .hit(hit), .txd(txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  // hist[k] is txd during the cycle following edge k
  always @(negedge clk) if (edge_n < MAXC) hist[edge_n] = txd;

  function automatic logic m_busy();
    return (edge_n - m_last_pop) < FRAME;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = (m_q.size() == DEPTH);
    s[1]   = (m_q.size() == 0);
    s[2]   = m_busy();
    s[3]   = m_ovf;
    s[6:4] = 3'(m_q.size());
    return s;
  endfunction

  // One clock edge of the reference: pop when the line is free, then accept/drop a store.
  task automatic model_edge(input int e, input logic rst, input logic push,
                            input logic [7:0] b, input logic clr);
    logic       pop;
    logic [7:0] head;
    if (rst) begin
      for (int i = e; i <= e + FRAME && i < MAXC; i++) exp_txd[i] = 1'b1;
      m_q.delete();
      m_ovf      = 1'b0;
      m_last_pop = -100000;
      m_free     = 0;
    end else begin
      pop = (m_q.size() != 0) && (e >= m_free);
      if (pop) begin
        head       = m_q.pop_front();
        m_last_pop = e;
        m_free     = e + FRAME + 1;
        for (int j = 0; j < 10; j++)
          for (int k = 0; k < C; k++)
            if (e + 1 + C * j + k < MAXC)
              exp_txd[e + 1 + C * j + k] = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : head[j-1];
      end
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else m_ovf = 1'b1;
      end
      if (clr) m_ovf = 1'b0;
    end
  endtask

  task automatic tick(input logic mw, input logic [31:0] adr, input logic [31:0] wd);
    memwrite  = mw;
    dataadr   = adr;
    writedata = wd;
    @(posedge clk);
    #1;
    model_edge(edge_n, reset, mw && (adr == BASE), wd[7:0], mw && (adr == STAT));
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
  endtask

  task automatic read_adr(input logic [31:0] adr, output logic h, output logic [31:0] d);
    memwrite = 1'b0;
    dataadr  = adr;
    #1;
    h       = hit;
    d       = rdata;
    dataadr = '0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_q.size() != 0 || m_busy()) && guard < 2000) begin
      tick(1'b0, '0, '0);
      guard++;
    end
    tick(1'b0, '0, '0);
    tick(1'b0, '0, '0);
  endtask

  task automatic test_reset();
    logic h;
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) tick(1'b0, '0, '0);
    reset = 1'b0;
    n_checks++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", txd); end
    read_adr(STAT, h, d);
    n_checks++;
    if (h !== 1'b1) begin n_fail++; $display("FAIL reset_hit_status: got %b want 1", h); end
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL reset_status: got %h want 00000002", d); end
    read_adr(BASE, h, d);
    n_checks++;
    if (h !== 1'b0) begin n_fail++; $display("FAIL reset_hit_txdata: got %b want 0", h); end
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_txdata: got %h want 0", d); end
  endtask

  task automatic test_single_frame();
    int e;
    logic h;
    logic [31:0] d;
    logic [39:0] got;
    logic [39:0] want;
    logic [7:0] v;
    v = 8'hA5;
    tick(1'b1, BASE, 32'h0000_00A5);
    e = edge_n;
    read_adr(STAT, h, d);
    n_checks++;
    if (d !== 32'h0000_0010) begin n_fail++; $display("FAIL single_count_after_store: got %h want 00000010", d); end
    for (int i = 1; i <= 43; i++) begin
      tick(1'b0, '0, '0);
      if (i == 2) begin
        read_adr(STAT, h, d);
        n_checks++;
        if (d !== m_status() || d[2] !== 1'b1)
          begin n_fail++; $display("FAIL single_busy_start: got %h want %h", d, m_status()); end
      end
      if (i == 43) begin
        read_adr(STAT, h, d);
        n_checks++;
        if (d[2] !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", d[2]); end
      end
    end
    for (int i = 0; i < 40; i++) begin
      got[i] = hist[e + 2 + i];
      if (i < 4) want[i] = 1'b0;
      else if (i < 36) want[i] = v[(i - 4) / 4];
      else want[i] = 1'b1;
    end
    n_checks++;
    if (hist[e + 1] !== 1'b1) begin n_fail++; $display("FAIL single_idle_before_start: got %b want 1", hist[e + 1]); end
    n_checks++;
    if (got[3:0] !== 4'h0) begin n_fail++; $display("FAIL single_start_bit: got %b want 0000", got[3:0]); end
    n_checks++;
    if (got[35:4] !== want[35:4]) begin n_fail++; $display("FAIL single_data_bits: got %h want %h", got[35:4], want[35:4]); end
    n_checks++;
    if (got[39:36] !== 4'hF) begin n_fail++; $display("FAIL single_stop_bit: got %b want 1111", got[39:36]); end
  endtask

  task automatic test_back_to_back();
    int e1;
    int f1;
    int f2;
    logic h;
    logic [31:0] d;
    tick(1'b1, BASE, 32'h0000_0055);
    e1 = edge_n;
    read_adr(STAT, h, d);
    n_checks++;
    if (d !== m_status()) begin n_fail++; $display("FAIL b2b_status_first: got %h want %h", d, m_status()); end
    tick(1'b1, BASE, 32'h0000_000F);
    read_adr(STAT, h, d);
    n_checks++;
    if (d !== m_status()) begin n_fail++; $display("FAIL b2b_status_second: got %h want %h", d, m_status()); end
    for (int i = 0; i < 90; i++) begin
      tick(1'b0, '0, '0);
      read_adr(STAT, h, d);
      n_checks++;
      if (d !== m_status()) begin n_fail++; $display("FAIL b2b_status_edge%0d: got %h want %h", edge_n, d, m_status()); end
    end
    f1 = -1;
    for (int i = e1 + 1; i < e1 + 60 && f1 < 0; i++)
      if (hist[i-1] === 1'b1 && hist[i] === 1'b0) f1 = i;
    f2 = -1;
    if (f1 > 0)
      for (int i = f1 + FRAME; i < f1 + FRAME + 20 && f2 < 0; i++)
        if (hist[i-1] === 1'b1 && hist[i] === 1'b0) f2 = i;
    n_checks++;
    if (f1 != e1 + 2) begin n_fail++; $display("FAIL b2b_first_start: got %0d want %0d", f1, e1 + 2); end
    n_checks++;
    if (f2 - f1 != FRAME + 1) begin n_fail++; $display("FAIL b2b_start_spacing: got %0d want %0d", f2 - f1, FRAME + 1); end
  endtask

  task automatic test_overflow();
    logic h;
    logic [31:0] d;
    tick(1'b1, BASE, 32'h0000_003C);
    tick(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) tick(1'b1, BASE, 32'($urandom_range(0, 255)));
    read_adr(STAT, h, d);
    n_checks++;
    if (d !== 32'h0000_004D) begin n_fail++; $display("FAIL ovf_status_set: got %h want 0000004d", d); end
    n_checks++;
    if (d !== m_status()) begin n_fail++; $display("FAIL ovf_status_model: got %h want %h", d, m_status()); end
    tick(1'b1, STAT, 32'h0);
    read_adr(STAT, h, d);
    n_checks++;
    if (d !== 32'h0000_0045) begin n_fail++; $display("FAIL ovf_status_cleared: got %h want 00000045", d); end
    drain();
    read_adr(STAT, h, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL ovf_drained: got %h want 00000002", d); end
  endtask

  task automatic test_collision();
    logic h;
    logic [31:0] d;
    int target;
    int guard;
    tick(1'b1, BASE, 32'h0000_00C3);
    tick(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) tick(1'b1, BASE, 32'($urandom_range(0, 255)));
    target = m_free;
    guard = 0;
    while (edge_n < target - 1 && guard < 200) begin
      tick(1'b0, '0, '0);
      guard++;
    end
    tick(1'b1, BASE, 32'h0000_0096);
    read_adr(STAT, h, d);
    n_checks++;
    if (d !== 32'h0000_0045) begin n_fail++; $display("FAIL collide_status: got %h want 00000045", d); end
    n_checks++;
    if (d !== m_status()) begin n_fail++; $display("FAIL collide_status_model: got %h want %h", d, m_status()); end
    drain();
  endtask

  task automatic test_reset_midframe();
    logic h;
    logic [31:0] d;
    int r;
    int zeros;
    for (int i = 0; i < 3; i++) tick(1'b1, BASE, 32'($urandom_range(0, 255)));
    repeat (15) tick(1'b0, '0, '0);
    reset = 1'b1;
    tick(1'b0, '0, '0);
    reset = 1'b0;
    r = edge_n;
    n_checks++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL midreset_txd: got %b want 1", txd); end
    read_adr(STAT, h, d);
    n_checks++;
    if (d !== 32'h0000_0002) begin n_fail++; $display("FAIL midreset_status: got %h want 00000002", d); end
    repeat (100) tick(1'b0, '0, '0);
    zeros = 0;
    for (int i = r; i < r + 100; i++) if (hist[i] !== 1'b1) zeros++;
    n_checks++;
    if (zeros != 0) begin n_fail++; $display("FAIL midreset_line_quiet: got %0d low cycles want 0", zeros); end
  endtask

  task automatic test_random();
    logic h;
    logic [31:0] d;
    logic [31:0] adr;
    logic [31:0] exp_d;
    int r;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      tick(1'b1, BASE, $urandom);
      else if (r < 34) tick(1'b1, STAT, $urandom);
      else if (r < 38) tick(1'b1, BASE + 32'($urandom_range(1, 3)), $urandom);
      else if (r < 40) tick(1'b1, BASE + 32'd8, $urandom);
      else             tick(1'b0, '0, '0);
      r = $urandom_range(0, 9);
      adr = (r < 7) ? STAT : (r == 7) ? BASE : (r == 8) ? STAT + 32'd4 : $urandom;
      read_adr(adr, h, d);
      exp_d = (adr == STAT) ? m_status() : 32'h0;
      n_checks++;
      if (h !== (adr == STAT) || d !== exp_d)
        begin n_fail++; $display("FAIL random_read adr=%h: got hit=%b data=%h want hit=%b data=%h", adr, h, d, adr == STAT, exp_d); end
    end
    drain();
  endtask

  task automatic test_waveform();
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int i = 1; i < edge_n && i < MAXC; i++)
      if (hist[i] !== exp_txd[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    n_checks++;
    if (bad != 0)
      begin n_fail++; $display("FAIL txd_waveform: got %0d differing cycles (first at %0d, txd=%b) want 0", bad, first, hist[first]); end
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) exp_txd[i] = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_collision();
    test_reset_midframe();
    test_random();
    test_waveform();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
